piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in/serial-out converter, the inverse of the FIR serial-in/parallel-out tap shift register. Accepts a full vector of NUM_REGS words in one handshake and emits them one word per accepted beat on a valid/ready serial stream. It feeds tap or coefficient vectors back into serial datapaths. Output order is chosen so that a serial-in/parallel-out tap register fed by this block reconstructs the original vector.

Parameters:
- NUM_REGS, 8, number of words per parallel vector (must be >= 2)
- DATA_WIDTH, `DATA_WIDTH (header.vh, 16), word width in bits

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- pDataIn  input  DATA_WIDTH x NUM_REGS  parallel vector, index 0..NUM_REGS-1
- pValid  input  1  parallel vector valid
- pReady  output  1  block can accept a vector this cycle
- serialDataOut  output  DATA_WIDTH  current serial word
- sValid  output  1  serialDataOut valid
- sReady  input  1  downstream accepts the serial word
- sLast  output  1  final word of the vector (present only with PISO_LAST_EN)

Behaviour:
- Reset: on clk edge with rst=1, state=IDLE, buffer cleared to 0, beat count=0, sValid=0, serialDataOut=0, pReady=0 during the reset cycle and 1 on the first cycle after.
- Reset mid-vector: any words not yet sent are discarded. No partial completion occurs.
- Vector accept: occurs on a cycle with pValid and pReady both high. The whole pDataIn is captured into the internal buffer. Count is set to NUM_REGS-1 and state becomes SHIFT.
- Emit order: index NUM_REGS-1 first, then down to index 0 last.
- Output timing: serialDataOut and sValid are registered. The first word appears the cycle after acceptance (latency 1).
- Serial beat: occurs on a cycle with sValid and sReady both high. The buffer shifts by one word toward the output and count decrements.
- Stall: with sValid=1 and sReady=0, serialDataOut and sValid hold stable. Data must not change while valid and not accepted.
- States:
  - IDLE: sValid=0, pReady=1. On accept, go to SHIFT.
  - SHIFT: sValid=1. After the last beat (count==0 and sReady=1), go to IDLE, or stay in SHIFT if a new vector is accepted on the same cycle.
- pReady = (state==IDLE) OR (state==SHIFT AND count==0 AND sReady). This allows back-to-back vectors with zero bubble cycles.
- Simultaneous last beat and new accept: the new vector loads, and its word NUM_REGS-1 is presented the next cycle. sValid stays 1 continuously.
- pValid while not pReady: ignored. Upstream holds pDataIn per the handshake.
- Count width: $clog2(NUM_REGS). Count never wraps below 0.

Optional Feature:
- Macro: PISO_LAST_EN.
- Defined: adds the sLast output, registered and aligned with serialDataOut. sLast=1 exactly when count==0 and sValid=1. sLast resets to 0.
- Undefined: the sLast port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared constants stay in header.vh: `DATA_WIDTH and the NUM_REGS default. No new package is required.
- The count width is derived locally via $clog2.
- One natural sub-module: piso_beat_counter, a loadable down-counter with a zero flag. It is optional, and the block may inline it.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> sValid=0, serialDataOut=0, pReady=1 on the first post-reset cycle.
- Basic vector: load pDataIn={0x0001..0x0008} (index 0=0x0001) with sReady=1 throughout -> words 0x0008,0x0007,...,0x0001 on 8 consecutive cycles starting 1 cycle after accept. sLast is high only on 0x0001 (with PISO_LAST_EN).
- Backpressure: toggle sReady pseudo-randomly -> serialDataOut stable during stalls, no word lost or duplicated, 8 beats total.
- Back-to-back: present vector A, then vector B with pValid held -> B accepted on A's last beat, 16 contiguous valid beats with no bubble.
- Reset mid-vector: assert rst after 3 beats -> sValid=0 the next cycle. A new vector then starts from index NUM_REGS-1 with no residual words.
- Round trip: connect serialDataOut to the tap shift register input, gated by the beat handshake -> after 8 beats its parallel output equals the original pDataIn.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared constants and state encoding for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  localparam int unsigned PISO_DATA_WIDTH = 16;
  localparam int unsigned PISO_NUM_REGS   = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } piso_state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-vector and serial-stream handshake bundle for piso_serializer.
// sLast exists only when PISO_LAST_EN is defined.
interface piso_serializer_if
  import piso_serializer_pkg::*;
#(
  parameter int unsigned NUM_REGS   = PISO_NUM_REGS,
  parameter int unsigned DATA_WIDTH = PISO_DATA_WIDTH
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] pDataIn;
  logic                                pValid;
  logic                                pReady;
  logic [DATA_WIDTH-1:0]               serialDataOut;
  logic                                sValid;
  logic                                sReady;
`ifdef PISO_LAST_EN
  logic                                sLast;

  modport master (
    output pDataIn, pValid, sReady,
    input  pReady, serialDataOut, sValid, sLast
  );

  modport slave (
    input  pDataIn, pValid, sReady,
    output pReady, serialDataOut, sValid, sLast
  );
`else
  modport master (
    output pDataIn, pValid, sReady,
    input  pReady, serialDataOut, sValid
  );

  modport slave (
    input  pDataIn, pValid, sReady,
    output pReady, serialDataOut, sValid
  );
`endif

endinterface

// File: rtl/piso_beat_counter.sv
// Loadable down-counter tracking words remaining in the current vector; saturates at 0.
module piso_beat_counter #(
  parameter  int unsigned NUM_REGS = 8,
  localparam int unsigned CW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(NUM_REGS - 1);
    end else if (dec && !zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: word NUM_REGS-1 is emitted first, word 0 last.
// Define PISO_LAST_EN to add the registered sLast output.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned NUM_REGS   = PISO_NUM_REGS,
  parameter int unsigned DATA_WIDTH = PISO_DATA_WIDTH
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(NUM_REGS);

  piso_state_e                         state;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] shreg;
  logic                                svalid;
  logic [CW-1:0]                       count;
  logic                                cnt_zero;
  logic                                p_ready;
  logic                                accept;
  logic                                beat;

  assign p_ready = !rst && ((state == IDLE) ||
                            (state == SHIFT && cnt_zero && bus.sReady));
  assign accept  = bus.pValid && p_ready;
  assign beat    = svalid && bus.sReady;

  assign bus.pReady        = p_ready;
  assign bus.sValid        = svalid;
  assign bus.serialDataOut = shreg[NUM_REGS-1];

  piso_beat_counter #(.NUM_REGS(NUM_REGS)) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .dec   (beat),
    .count (count),
    .zero  (cnt_zero)
  );

  // The top buffer word is the output register; shifting zeros in means the
  // last beat leaves serialDataOut at 0 when no new vector follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      svalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= bus.pDataIn;
            svalid <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sReady) begin
            if (accept) begin
              shreg <= bus.pDataIn;
            end else begin
              shreg <= {shreg[NUM_REGS-2:0], DATA_WIDTH'(0)};
              if (cnt_zero) begin
                svalid <= 1'b0;
                state  <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PISO_LAST_EN
  logic slast;

  always_ff @(posedge clk) begin
    if (rst) begin
      slast <= 1'b0;
    end else if (accept) begin
      slast <= 1'b0;
    end else if (beat) begin
      slast <= (count == CW'(1));
    end
  end

  assign bus.sLast = slast;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer with a word-order scoreboard and a tap-register round trip.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int unsigned N = PISO_NUM_REGS;
  localparam int unsigned W = PISO_DATA_WIDTH;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;

  piso_serializer_if #(.NUM_REGS(N), .DATA_WIDTH(W)) bus();

  piso_serializer #(.NUM_REGS(N), .DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned    checks = 0;
  int unsigned    passes = 0;
  int unsigned    fails  = 0;
  int unsigned    beats  = 0;
  int unsigned    run    = 0;
  int unsigned    max_run = 0;
  logic [W-1:0]   q[$];
  logic [W-1:0]   e;
  vec_t           tap;
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_d;
  vec_t           v1, v2, va, vb, v3, v4;
  int unsigned    b0;
  int unsigned    n;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream tap register: shifts in at index 0 on every accepted beat.
  always @(posedge clk) begin
    if (rst) tap <= '0;
    else if (bus.sValid && bus.sReady) tap <= {tap[N-2:0], bus.serialDataOut};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", 128'(bus.sValid), 128'(1));
        chk("stall_data", 128'(bus.serialDataOut), 128'(prev_d));
      end
      if (bus.sValid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (bus.sValid && bus.sReady) begin
        chk("beat_expected", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("word", 128'(bus.serialDataOut), 128'(e));
`ifdef PISO_LAST_EN
          chk("slast", 128'(bus.sLast), 128'(q.size() == 0));
`endif
        end
        beats++;
      end
      prev_stall = bus.sValid && !bus.sReady;
      prev_d     = bus.serialDataOut;
    end else begin
      prev_stall = 1'b0;
      run        = 0;
    end
  end

  task automatic send_vec(input vec_t v, input bit drop);
    int unsigned k = 0;
    bit got = 1'b0;
    bus.pDataIn = v;
    bus.pValid  = 1'b1;
    while (!got && k < 100) begin
      @(negedge clk);
      got = bus.pReady && !rst;
      @(posedge clk); #1;
      k++;
    end
    chk("accept", 128'(got), 128'(1));
    if (got) begin
      for (int i = N - 1; i >= 0; i--) q.push_back(v[i]);
      chk("first_valid", 128'(bus.sValid), 128'(1));
      chk("first_word", 128'(bus.serialDataOut), 128'(v[N-1]));
    end
    if (drop) bus.pValid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int unsigned k = 0;
    while (q.size() != 0 && k < 400) begin
      bus.sReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk("drain_done", 128'(q.size()), 128'(0));
    bus.sReady = 1'b1;
    chk("idle_after", 128'(bus.sValid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      v1[i] = W'(i + 1);
      v2[i] = W'($urandom);
      va[i] = W'(16'hA000 + i);
      vb[i] = W'(16'hB000 + i);
      v3[i] = W'($urandom);
      v4[i] = W'($urandom);
    end

    rst         = 1'b1;
    bus.pValid  = 1'b0;
    bus.pDataIn = '0;
    bus.sReady  = 1'b0;
    @(negedge clk);
    chk("pready_in_reset", 128'(bus.pReady), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_svalid", 128'(bus.sValid), 128'(0));
    chk("reset_data", 128'(bus.serialDataOut), 128'(0));
    chk("reset_pready", 128'(bus.pReady), 128'(1));
`ifdef PISO_LAST_EN
    chk("reset_slast", 128'(bus.sLast), 128'(0));
`endif
    @(posedge clk); #1;

    // Basic vector, no backpressure
    bus.sReady = 1'b1;
    b0 = beats;
    send_vec(v1, 1'b1);
    drain(1'b0);
    chk("basic_beats", 128'(beats - b0), 128'(8));
    chk("basic_roundtrip", 128'(tap), 128'(v1));

    // Random backpressure
    b0 = beats;
    send_vec(v2, 1'b1);
    drain(1'b1);
    chk("bp_beats", 128'(beats - b0), 128'(8));
    chk("bp_roundtrip", 128'(tap), 128'(v2));

    // Back-to-back vectors with pValid held
    bus.sReady = 1'b1;
    max_run = 0;
    b0 = beats;
    send_vec(va, 1'b0);
    send_vec(vb, 1'b1);
    drain(1'b0);
    chk("b2b_beats", 128'(beats - b0), 128'(16));
    chk("b2b_no_bubble", 128'(max_run), 128'(16));
    chk("b2b_roundtrip", 128'(tap), 128'(vb));

    // Reset after three beats, then a fresh vector
    send_vec(v3, 1'b1);
    b0 = beats;
    n = 0;
    while (beats < b0 + 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_beats", 128'(beats - b0), 128'(3));
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("mid_rst_svalid", 128'(bus.sValid), 128'(0));
    chk("mid_rst_data", 128'(bus.serialDataOut), 128'(0));
    chk("mid_rst_pready", 128'(bus.pReady), 128'(0));
    rst = 1'b0;
    b0 = beats;
    send_vec(v4, 1'b1);
    drain(1'b0);
    chk("post_rst_beats", 128'(beats - b0), 128'(8));
    chk("post_rst_roundtrip", 128'(tap), 128'(v4));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
